// File: rtl/upper_pc_table.sv
// upper_pc_table: fully associative store of upper-PC fields shared by BTB entries, with tree-PLRU replacement.
// Ports:
//   CLK, RST                        clock and asynchronous active-high reset
//   read_valid, read_index          lookup of a stored upper PC by index (prediction path)
//   read_upper_PC, read_resp_valid  registered lookup result, one cycle later
//   write_valid, write_upper_PC     locate-or-insert request (BTB update path)
//   write_index, write_hit,
//   write_resp_valid                registered slot now holding the value and whether it was already present
module upper_pc_table #(
    parameter int UPPER_PC_TABLE_ENTRIES = 8,
    parameter int UPPER_PC_WIDTH = 21
) (
    input  logic                                      CLK,
    input  logic                                      RST,
    input  logic                                      read_valid,
    input  logic [$clog2(UPPER_PC_TABLE_ENTRIES)-1:0] read_index,
    output logic [UPPER_PC_WIDTH-1:0]                 read_upper_PC,
    output logic                                      read_resp_valid,
    input  logic                                      write_valid,
    input  logic [UPPER_PC_WIDTH-1:0]                 write_upper_PC,
    output logic [$clog2(UPPER_PC_TABLE_ENTRIES)-1:0] write_index,
    output logic                                      write_hit,
    output logic                                      write_resp_valid
);
    localparam int N = UPPER_PC_TABLE_ENTRIES;
    localparam int IW = $clog2(N);
    logic [N-1:0]              valid_q;
    logic [UPPER_PC_WIDTH-1:0] tag_q [N];
    logic [N-2:0]              plru_q, plru_d;
    logic [UPPER_PC_WIDTH-1:0] rdata_q;
    logic                      rvalid_q, wvalid_q, whit_q;
    logic [IW-1:0]             widx_q;
    logic                      hit;
    logic [IW-1:0]             hit_idx, free_idx, plru_vic, widx, node;
    // Heap-ordered tree: children of node n are 2n+1 (lower half) and 2n+2 (upper half).
    // Each node on the path of i is pointed at the sibling subtree.
    function automatic logic [N-2:0] touch(input logic [N-2:0] p, input logic [IW-1:0] i);
        logic [N-2:0] t;
        logic [IW-1:0] n;
        t = p;
        n = '0;
        for (int l = 0; l < IW; l++) begin
            t[n] = ~i[IW-1-l];
            n = {n[IW-2:0], 1'b0} + IW'(1) + IW'(i[IW-1-l]);
        end
        return t;
    endfunction
    always_comb begin
        hit = 1'b0;
        hit_idx = '0;
        free_idx = '0;
        // Descending scan so the lowest-index invalid slot is the one left in free_idx.
        for (int e = N - 1; e >= 0; e--) begin
            if (valid_q[e] && tag_q[e] == write_upper_PC) begin
                hit = 1'b1;
                hit_idx = IW'(e);
            end
            if (!valid_q[e]) free_idx = IW'(e);
        end
        node = '0;
        plru_vic = '0;
        for (int l = 0; l < IW; l++) begin
            plru_vic[IW-1-l] = plru_q[node];
            node = {node[IW-2:0], 1'b0} + IW'(1) + IW'(plru_q[node]);
        end
        widx = hit ? hit_idx : (&valid_q ? plru_vic : free_idx);
        // Read touch first so the write touch wins on shared nodes; victim uses pre-touch state.
        plru_d = plru_q;
        if (read_valid) plru_d = touch(plru_d, read_index);
        if (write_valid) plru_d = touch(plru_d, widx);
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_q <= '0;
            for (int e = 0; e < N; e++) tag_q[e] <= '0;
            plru_q <= '0;
            rdata_q <= '0;
            rvalid_q <= 1'b0;
            wvalid_q <= 1'b0;
            whit_q <= 1'b0;
            widx_q <= '0;
        end else begin
            plru_q <= plru_d;
            rvalid_q <= read_valid;
            wvalid_q <= write_valid;
            if (read_valid) rdata_q <= tag_q[read_index];
            if (write_valid) begin
                widx_q <= widx;
                whit_q <= hit;
                if (!hit) begin
                    valid_q[widx] <= 1'b1;
                    tag_q[widx] <= write_upper_PC;
                end
            end
        end
    end
    assign read_upper_PC = rdata_q;
    assign read_resp_valid = rvalid_q;
    assign write_index = widx_q;
    assign write_hit = whit_q;
    assign write_resp_valid = wvalid_q;
endmodule

// File: tb/tb_upper_pc_table.sv
// tb_upper_pc_table: self-checking bench for upper_pc_table against a behavioural PLRU table model.
module tb_upper_pc_table;
    logic        CLK, RST;
    logic        read_valid, write_valid;
    logic [2:0]  read_index;
    logic [20:0] read_upper_PC, write_upper_PC;
    logic        read_resp_valid, write_hit, write_resp_valid;
    logic [2:0]  write_index;

    upper_pc_table dut (
        .CLK(CLK), .RST(RST),
        .read_valid(read_valid), .read_index(read_index),
        .read_upper_PC(read_upper_PC), .read_resp_valid(read_resp_valid),
        .write_valid(write_valid), .write_upper_PC(write_upper_PC),
        .write_index(write_index), .write_hit(write_hit), .write_resp_valid(write_resp_valid)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int total = 0;
    int bad = 0;

    // reference model: contents, valid flags, tree nodes and expected registered outputs
    bit          mv [8];
    logic [20:0] mt [8];
    bit          mp [7];
    logic [20:0] e_rd;
    bit          e_rv, e_wv, e_hit;
    int          e_idx;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 8; i++) begin mv[i] = 1'b0; mt[i] = '0; end
        for (int n = 0; n < 7; n++) mp[n] = 1'b0;
        e_rd = '0; e_rv = 1'b0; e_wv = 1'b0; e_hit = 1'b0; e_idx = 0;
    endtask

    // node at depth l on the path to leaf i: first node of level l plus i's prefix
    function automatic int m_node(input int l, input int i);
        return (1 << l) - 1 + (i >> (3 - l));
    endfunction

    // victim = lowest invalid slot, else the unique leaf whose ancestors all point toward it
    function automatic int m_victim();
        for (int i = 0; i < 8; i++) if (!mv[i]) return i;
        for (int i = 0; i < 8; i++) begin
            bit ok = 1'b1;
            for (int l = 0; l < 3; l++)
                if (int'(mp[m_node(l, i)]) != ((i >> (2 - l)) & 1)) ok = 1'b0;
            if (ok) return i;
        end
        return -1;
    endfunction

    task automatic m_touch(input int i);
        for (int l = 0; l < 3; l++) mp[m_node(l, i)] = (((i >> (2 - l)) & 1) == 0);
    endtask

    task automatic m_step(input bit rv, input int ri, input bit wv, input logic [20:0] wpc);
        int w = 0;
        bit h = 1'b0;
        e_rv = rv;
        e_wv = wv;
        if (rv) e_rd = mt[ri];
        if (wv) begin
            w = m_victim();
            for (int i = 0; i < 8; i++) if (mv[i] && mt[i] == wpc) begin h = 1'b1; w = i; end
            e_idx = w;
            e_hit = h;
        end
        if (rv) m_touch(ri);
        if (wv) begin
            m_touch(w);
            if (!h) begin mv[w] = 1'b1; mt[w] = wpc; end
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rd"}, 32'(read_upper_PC), 32'd0);
        chk({tag, "_rv"}, 32'(read_resp_valid), 32'd0);
        chk({tag, "_idx"}, 32'(write_index), 32'd0);
        chk({tag, "_hit"}, 32'(write_hit), 32'd0);
        chk({tag, "_wv"}, 32'(write_resp_valid), 32'd0);
    endtask

    // called just after a rising edge; applies one cycle of requests and checks against the model
    task automatic step(input bit rv, input logic [2:0] ri, input bit wv, input logic [20:0] wpc);
        read_valid = rv; read_index = ri; write_valid = wv; write_upper_PC = wpc;
        m_step(rv, int'(ri), wv, wpc);
        @(posedge CLK);
        #1;
        chk("read_resp_valid", 32'(read_resp_valid), 32'(e_rv));
        chk("write_resp_valid", 32'(write_resp_valid), 32'(e_wv));
        chk("read_upper_PC", 32'(read_upper_PC), 32'(e_rd));
        chk("write_index", 32'(write_index), 32'(e_idx));
        chk("write_hit", 32'(write_hit), 32'(e_hit));
        read_valid = 1'b0; write_valid = 1'b0;
    endtask

    // requests held during reset must be dropped
    task automatic do_reset();
        read_valid = 1'b1; read_index = 3'd5; write_valid = 1'b1; write_upper_PC = 21'h1FFFF;
        RST = 1'b1;
        #1;
        chk_zero("reset");
        m_reset();
        @(posedge CLK);
        #1;
        read_valid = 1'b0; write_valid = 1'b0;
        RST = 1'b0;
    endtask

    typedef struct {
        bit          rv;
        logic [2:0]  ri;
        bit          wv;
        logic [20:0] wpc;
        logic [2:0]  e_idx;
        bit          e_hit;
        logic [20:0] e_rd;
    } vec_t;

    function automatic vec_t mk(input bit rv, input logic [2:0] ri, input bit wv, input logic [20:0] wpc,
                                input logic [2:0] ei, input bit eh, input logic [20:0] er);
        vec_t v;
        v.rv = rv; v.ri = ri; v.wv = wv; v.wpc = wpc; v.e_idx = ei; v.e_hit = eh; v.e_rd = er;
        return v;
    endfunction

    logic [20:0] a [8];
    logic [20:0] pool [12];
    vec_t        tbl [11];
    localparam logic [20:0] B = 21'h0BEEF, C = 21'h0CAFE, D = 21'h0D00D, E = 21'h0E0E0;

    initial begin
        RST = 1'b0; read_valid = 1'b0; write_valid = 1'b0; read_index = '0; write_upper_PC = '0;
        for (int k = 0; k < 8; k++) a[k] = 21'h12345 + 21'(k) * 21'h01111;
        for (int k = 0; k < 12; k++) pool[k] = 21'h00107 + 21'(k) * 21'h00100;
        // fill (with an early read of slot 0), PLRU replacement, eviction and a rewrite hit
        tbl[0] = mk(1'b0, 3'd0, 1'b1, a[0], 3'd0, 1'b0, 21'h0);
        tbl[1] = mk(1'b1, 3'd0, 1'b1, a[1], 3'd1, 1'b0, a[0]);
        for (int k = 2; k < 8; k++) tbl[k] = mk(1'b0, 3'd0, 1'b1, a[k], 3'(k), 1'b0, a[0]);
        tbl[8]  = mk(1'b0, 3'd0, 1'b1, B,    3'd0, 1'b0, a[0]);
        tbl[9]  = mk(1'b1, 3'd0, 1'b1, a[0], 3'd4, 1'b0, B);
        tbl[10] = mk(1'b0, 3'd0, 1'b1, a[3], 3'd3, 1'b1, B);
        #2;
        do_reset();
        step(1'b0, 3'd0, 1'b0, 21'h0);
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].rv, tbl[i].ri, tbl[i].wv, tbl[i].wpc);
            chk($sformatf("tbl%0d_idx", i), 32'(write_index), 32'(tbl[i].e_idx));
            chk($sformatf("tbl%0d_hit", i), 32'(write_hit), 32'(tbl[i].e_hit));
            chk($sformatf("tbl%0d_rd", i), 32'(read_upper_PC), 32'(tbl[i].e_rd));
        end

        // same-cycle read of the slot being replaced sees the old value
        do_reset();
        for (int k = 0; k < 8; k++) step(1'b0, 3'd0, 1'b1, a[k]);
        step(1'b1, 3'd0, 1'b1, C);
        chk("replace_old_rd", 32'(read_upper_PC), 32'(a[0]));
        chk("replace_idx", 32'(write_index), 32'd0);
        step(1'b1, 3'd0, 1'b0, 21'h0);
        chk("replace_new_rd", 32'(read_upper_PC), 32'(C));

        // a read touch protects its slot from the next victim choice
        step(1'b1, 3'd4, 1'b0, 21'h0);
        step(1'b0, 3'd0, 1'b1, D);
        chk("touch_protects_4", 32'(write_index != 3'd4), 32'd1);

        // asynchronous reset in the middle of a write burst
        step(1'b0, 3'd0, 1'b1, pool[0]);
        step(1'b1, 3'd2, 1'b1, pool[1]);
        write_valid = 1'b1; write_upper_PC = pool[2]; read_valid = 1'b1; read_index = 3'd1;
        #3;
        RST = 1'b1;
        #1;
        chk_zero("async_rst");
        m_reset();
        @(posedge CLK);
        #1;
        chk_zero("rst_held");
        RST = 1'b0; write_valid = 1'b0; read_valid = 1'b0;
        step(1'b0, 3'd0, 1'b0, 21'h0);
        step(1'b0, 3'd0, 1'b1, E);
        chk("post_rst_idx", 32'(write_index), 32'd0);
        chk("post_rst_hit", 32'(write_hit), 32'd0);

        // random traffic from a small pool so hits, misses and evictions all occur
        do_reset();
        for (int n = 0; n < 400; n++)
            step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 pool[$urandom_range(0, 11)]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/upper_pc_table.md
UPPER_PC_TABLE -- requirements
Module: upper_pc_table

Interface
REQ-001: Parameter UPPER_PC_TABLE_ENTRIES, default 8, number of table entries; power of two, 8 for this release.
REQ-002: Parameter UPPER_PC_WIDTH, default 21, width of a stored upper-PC field (32 - BTB_TARGET_WIDTH - 1).
REQ-003: One clock; reset is asynchronous and active-high.
REQ-004: CLK  input  1  clock; all state updates on rising edge.
REQ-005: RST  input  1  asynchronous active-high reset.
REQ-006: read_valid  input  1  lookup request from prediction path.
REQ-007: read_index  input  3  table index carried in a BTB entry.
REQ-008: read_upper_PC  output  21  registered upper PC for the previous cycle's read_index.
REQ-009: read_resp_valid  output  1  registered; high one cycle after read_valid.
REQ-010: write_valid  input  1  insert/lookup request from BTB update path.
REQ-011: write_upper_PC  input  21  upper PC to locate or insert.
REQ-012: write_index  output  3  registered index now holding write_upper_PC.
REQ-013: write_hit  output  1  registered; 1 if write_upper_PC was already present.
REQ-014: write_resp_valid  output  1  registered; high one cycle after write_valid.

Function
REQ-015: State: per entry a valid bit and UPPER_PC_WIDTH value; 7-bit tree PLRU (node0 root; node1 covers 0-3, node2 4-7; node3 0-1, node4 2-3, node5 4-5, node6 6-7).
REQ-016: PLRU node bit 0 = victim side is lower-index half, 1 = upper half; all-zero state selects index 0.
REQ-017: Touching index i sets every node on i's path to point away from i.
REQ-018: Read: latency 1; read_upper_PC = stored value of read_index as of the cycle of request, regardless of valid bit.
REQ-019: Read with read_valid touches read_index in the PLRU.
REQ-020: Write: compare write_upper_PC against all valid entries in the request cycle; on match, write_index = matching index, write_hit = 1, no table change.
REQ-021: Write miss: victim = lowest-index invalid entry if any, else PLRU victim from current register state; entry set valid with write_upper_PC; write_hit = 0.
REQ-022: Write (hit or miss) touches write_index in the PLRU.
REQ-023: Same-cycle read and write: read touch applied first, write touch second (write wins on shared nodes); victim computed before either touch.
REQ-024: Same-cycle read of entry being replaced returns old contents; new value visible to reads issued the following cycle.
REQ-025: Hold: when read_valid/write_valid low, corresponding resp_valid goes 0 next cycle; data outputs hold last value.
REQ-026: No duplicate valid entries ever exist; multiple matches are impossible by construction.
REQ-027: Fully pipelined: one read and one write accepted every cycle, no backpressure.

Reset
REQ-028: On RST assertion, immediately and independent of CLK: all valid bits 0, entry values 0, PLRU bits 0, all outputs 0.
REQ-029: Requests present while RST is high are discarded; no response is produced for them after deassertion.

Verification
REQ-030: Reset, then write 0x12345 -> next cycle write_index=0, write_hit=0, write_resp_valid=1; read index 0 -> 0x12345.
REQ-031: Write A0..A7 (distinct) on consecutive cycles -> indices 0..7, all misses; rewrite A3 -> index 3, write_hit=1, table unchanged.
REQ-032: After REQ-031 fill, write new B -> write_index=0 (PLRU victim), hit=0; subsequent read 0 -> B, write A0 -> miss.
REQ-033: Full table, same cycle read index 0 and write new C replacing 0 -> read_upper_PC=old value, write_index=0; next-cycle read 0 -> C.
REQ-034: Full table, read 4 then write new D -> victim excludes 4 per PLRU model; bench compares against reference PLRU model each cycle.
REQ-035: Assert RST asynchronously mid-burst with write_valid=1 -> outputs 0 before next edge; after deassert, write E -> index 0, hit=0.
